// File: rtl/data_cache_pkg.sv
// Shared widths and FSM state type for the direct-mapped write-back data cache.
package data_cache_pkg;

   localparam int LINES    = 8;
   localparam int TAG_W    = 3;
   localparam int INDEX_W  = 3;
   localparam int OFFSET_W = 2;
   localparam int BLOCK_W  = 32;
   localparam int MADDR_W  = TAG_W + INDEX_W;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WRITEBACK = 2'd1,
      FETCH     = 2'd2
   } cache_state_t;

endpackage

// File: rtl/data_cache_line_array.sv
// Line storage: combinational read of one line, synchronous byte write or block fill, async clear.
module cache_line_array
   import data_cache_pkg::*;
(
   input  logic                clock,
   input  logic                reset,
   input  logic [INDEX_W-1:0]  index,
   output logic [BLOCK_W-1:0]  line_data,
   output logic [TAG_W-1:0]    line_tag,
   output logic                line_valid,
   output logic                line_dirty,
   input  logic                byte_we,
   input  logic [OFFSET_W-1:0] byte_offset,
   input  logic [7:0]          byte_data,
   input  logic                fill_we,
   input  logic [BLOCK_W-1:0]  fill_data,
   input  logic [TAG_W-1:0]    fill_tag
);

   logic [BLOCK_W-1:0] data_q  [LINES];
   logic [TAG_W-1:0]   tag_q   [LINES];
   logic [LINES-1:0]   valid_q;
   logic [LINES-1:0]   dirty_q;

   assign line_data  = data_q[index];
   assign line_tag   = tag_q[index];
   assign line_valid = valid_q[index];
   assign line_dirty = dirty_q[index];

   // A fill replaces the whole line and leaves it clean; a byte store only marks it dirty.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < LINES; i++) begin
            data_q[i] <= '0;
            tag_q[i]  <= '0;
         end
         valid_q <= '0;
         dirty_q <= '0;
      end else if (fill_we) begin
         data_q[index]  <= fill_data;
         tag_q[index]   <= fill_tag;
         valid_q[index] <= 1'b1;
         dirty_q[index] <= 1'b0;
      end else if (byte_we) begin
         data_q[index][{byte_offset, 3'b000} +: 8] <= byte_data;
         dirty_q[index] <= 1'b1;
      end
   end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped write-back write-allocate data cache: hit logic and miss-handling FSM.
module data_cache
   import data_cache_pkg::*;
(
   input  logic               clock,
   input  logic               reset,
   input  logic               read,
   input  logic               write,
   input  logic [7:0]         address,
   input  logic [7:0]         writedata,
   output logic [7:0]         readdata,
   output logic               busywait,
   output logic               mem_read,
   output logic               mem_write,
   output logic [MADDR_W-1:0] mem_address,
   output logic [BLOCK_W-1:0] mem_writedata,
   input  logic [BLOCK_W-1:0] mem_readdata,
   input  logic               mem_busywait
);

   cache_state_t state, next_state;
   logic         first_cycle;

   logic [TAG_W-1:0]    req_tag;
   logic [INDEX_W-1:0]  req_index;
   logic [OFFSET_W-1:0] req_offset;
   logic [BLOCK_W-1:0]  line_data;
   logic [TAG_W-1:0]    line_tag;
   logic                line_valid;
   logic                line_dirty;
   logic                valid_req;
   logic                hit;
   logic                byte_we;
   logic                fill_we;
   logic                mem_ready;

   assign req_tag    = address[7:5];
   assign req_index  = address[4:2];
   assign req_offset = address[1:0];
   assign valid_req  = read ^ write;
   assign hit        = line_valid && (line_tag == req_tag);
   assign readdata   = line_data[{req_offset, 3'b000} +: 8];
   assign mem_ready  = !first_cycle && !mem_busywait;

   cache_line_array u_lines (
      .clock       (clock),
      .reset       (reset),
      .index       (req_index),
      .line_data   (line_data),
      .line_tag    (line_tag),
      .line_valid  (line_valid),
      .line_dirty  (line_dirty),
      .byte_we     (byte_we),
      .byte_offset (req_offset),
      .byte_data   (writedata),
      .fill_we     (fill_we),
      .fill_data   (mem_readdata),
      .fill_tag    (req_tag)
   );

   // first_cycle masks mem_busywait on the edge that enters a memory state,
   // since the memory has not yet seen the new request at that point.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         first_cycle <= 1'b0;
      end else begin
         state       <= next_state;
         first_cycle <= (next_state != state);
      end
   end

   always_comb begin
      next_state    = state;
      busywait      = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      mem_address   = '0;
      mem_writedata = '0;
      byte_we       = 1'b0;
      fill_we       = 1'b0;
      case (state)
         IDLE: begin
            if (valid_req) begin
               if (hit) begin
                  byte_we = write;
               end else begin
                  busywait   = 1'b1;
                  next_state = line_dirty ? WRITEBACK : FETCH;
               end
            end
         end
         WRITEBACK: begin
            busywait      = valid_req;
            mem_write     = 1'b1;
            mem_address   = {line_tag, req_index};
            mem_writedata = line_data;
            if (mem_ready) next_state = FETCH;
         end
         FETCH: begin
            busywait    = valid_req;
            mem_read    = 1'b1;
            mem_address = {req_tag, req_index};
            if (mem_ready) begin
               fill_we    = 1'b1;
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
      // Never stall the CPU while the cache is being cleared.
      if (reset) busywait = 1'b0;
   end

endmodule

// File: tb/tb_data_cache.sv
// Self-checking bench: random loads/stores against a line-level reference model and a latency-randomised memory.
module tb_data_cache;

   logic        clock;
   logic        reset;
   logic        read;
   logic        write;
   logic [7:0]  address;
   logic [7:0]  writedata;
   logic [7:0]  readdata;
   logic        busywait;
   logic        mem_read;
   logic        mem_write;
   logic [5:0]  mem_address;
   logic [31:0] mem_writedata;
   logic [31:0] mem_readdata;
   logic        mem_busywait;

   data_cache dut (
      .clock         (clock),
      .reset         (reset),
      .read          (read),
      .write         (write),
      .address       (address),
      .writedata     (writedata),
      .readdata      (readdata),
      .busywait      (busywait),
      .mem_read      (mem_read),
      .mem_write     (mem_write),
      .mem_address   (mem_address),
      .mem_writedata (mem_writedata),
      .mem_readdata  (mem_readdata),
      .mem_busywait  (mem_busywait)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int check_count = 0;
   int error_count = 0;
   int wb_count    = 0;
   int fetch_count = 0;
   int excl_viol   = 0;
   logic [5:0]  last_wb_addr;
   logic [31:0] last_wb_data;
   logic [5:0]  last_fetch_addr;

   // Memory with random latency; finishing a transaction blocks a restart for one cycle
   logic [31:0] mem_array [64];
   logic        mem_done;
   int          mem_cnt;
   logic        op_write;
   logic [5:0]  op_addr;
   logic [31:0] op_data;

   always @(posedge clock or posedge reset) begin
      if (reset) begin
         mem_busywait <= 1'b0;
         mem_done     <= 1'b0;
         mem_cnt      <= 0;
      end else if (mem_busywait) begin
         if (mem_cnt <= 1) begin
            mem_busywait <= 1'b0;
            mem_done     <= 1'b1;
            if (op_write) begin
               mem_array[op_addr] = op_data;
               wb_count++;
               last_wb_addr = op_addr;
               last_wb_data = op_data;
            end else begin
               mem_readdata <= mem_array[op_addr];
               fetch_count++;
               last_fetch_addr = op_addr;
            end
         end else begin
            mem_cnt <= mem_cnt - 1;
         end
      end else if (mem_done) begin
         mem_done <= 1'b0;
      end else if (mem_read || mem_write) begin
         mem_busywait <= 1'b1;
         mem_cnt      <= int'($urandom_range(1, 4));
         op_write     <= mem_write;
         op_addr      <= mem_address;
         op_data      <= mem_writedata;
      end
   end

   always @(negedge clock) if (mem_read && mem_write) excl_viol++;

   // Reference model: cache lines as byte arrays plus the expected memory image
   logic       m_valid [8];
   logic       m_dirty [8];
   logic [2:0] m_tag   [8];
   logic [7:0] m_bytes [8][4];
   logic [31:0] m_mem  [64];

   function automatic void model_reset();
      for (int i = 0; i < 8; i++) begin
         m_valid[i] = 1'b0;
         m_dirty[i] = 1'b0;
         m_tag[i]   = 3'd0;
         for (int b = 0; b < 4; b++) m_bytes[i][b] = 8'h00;
      end
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      check_count++;
      if (got !== exp) begin
         error_count++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic applyStimulus(input logic rd, input logic wr, input logic [7:0] addr, input logic [7:0] wdata);
      int wb0, f0, cycles, idx, off;
      logic [2:0] tg;
      logic exp_hit, exp_wb;
      logic [5:0] exp_wb_addr;
      logic [31:0] exp_wb_data;
      wb0 = wb_count;
      f0  = fetch_count;
      idx = int'(addr[4:2]);
      off = int'(addr[1:0]);
      tg  = addr[7:5];
      @(negedge clock);
      read = rd; write = wr; address = addr; writedata = wdata;
      #1;
      if (rd && wr) begin
         checkOutput("ignored_busy", {31'd0, busywait}, 32'd0);
         repeat (3) @(negedge clock);
         checkOutput("ignored_traffic", wb_count - wb0 + fetch_count - f0, 32'd0);
         read = 1'b0; write = 1'b0;
         return;
      end
      exp_hit = m_valid[idx] && (m_tag[idx] == tg);
      checkOutput("busy_first", {31'd0, busywait}, {31'd0, !exp_hit});
      cycles = 0;
      while (busywait && cycles < 200) begin
         @(negedge clock);
         cycles++;
      end
      if (cycles >= 200) checkOutput("busy_timeout", 32'd1, 32'd0);
      exp_wb = 1'b0;
      exp_wb_addr = 6'd0;
      exp_wb_data = 32'd0;
      if (!exp_hit) begin
         if (m_valid[idx] && m_dirty[idx]) begin
            exp_wb      = 1'b1;
            exp_wb_addr = {m_tag[idx], addr[4:2]};
            exp_wb_data = {m_bytes[idx][3], m_bytes[idx][2], m_bytes[idx][1], m_bytes[idx][0]};
            m_mem[exp_wb_addr] = exp_wb_data;
         end
         for (int b = 0; b < 4; b++) m_bytes[idx][b] = m_mem[{tg, addr[4:2]}][8*b +: 8];
         m_valid[idx] = 1'b1;
         m_dirty[idx] = 1'b0;
         m_tag[idx]   = tg;
      end
      checkOutput("wb_count", wb_count - wb0, {31'd0, exp_wb});
      if (exp_wb) begin
         checkOutput("wb_addr", {26'd0, last_wb_addr}, {26'd0, exp_wb_addr});
         checkOutput("wb_data", last_wb_data, exp_wb_data);
      end
      checkOutput("fetch_count", fetch_count - f0, {31'd0, !exp_hit});
      if (!exp_hit) checkOutput("fetch_addr", {26'd0, last_fetch_addr}, {26'd0, tg, addr[4:2]});
      if (rd) checkOutput("readdata", {24'd0, readdata}, {24'd0, m_bytes[idx][off]});
      if (wr) begin
         m_bytes[idx][off] = wdata;
         m_dirty[idx] = 1'b1;
      end
      @(posedge clock);
      @(negedge clock);
      read = 1'b0; write = 1'b0;
   endtask

   initial begin
      int cycles;
      logic [7:0] a;
      int r;
      reset = 1'b1; read = 1'b1; write = 1'b0; address = 8'h00; writedata = 8'h00;
      for (int i = 0; i < 64; i++) begin
         m_mem[i]     = $urandom;
         mem_array[i] = m_mem[i];
      end
      m_mem[0]     = 32'h4433_2211;
      mem_array[0] = 32'h4433_2211;
      model_reset();
      #1;
      checkOutput("reset_busy", {31'd0, busywait}, 32'd0);
      checkOutput("reset_readdata", {24'd0, readdata}, 32'd0);
      checkOutput("reset_mem_read", {31'd0, mem_read}, 32'd0);
      read = 1'b0;
      repeat (3) @(negedge clock);
      reset = 1'b0;

      // Directed scenarios
      applyStimulus(1'b1, 1'b0, 8'h00, 8'h00);
      applyStimulus(1'b0, 1'b1, 8'h05, 8'hAB);
      applyStimulus(1'b1, 1'b0, 8'h05, 8'h00);
      applyStimulus(1'b0, 1'b1, 8'h25, 8'hCD);
      applyStimulus(1'b1, 1'b0, 8'h25, 8'h00);
      applyStimulus(1'b1, 1'b0, 8'h0A, 8'h00);
      applyStimulus(1'b1, 1'b0, 8'h0B, 8'h00);
      applyStimulus(1'b1, 1'b1, 8'h25, 8'h77);
      applyStimulus(1'b1, 1'b0, 8'h25, 8'h00);

      // Reset while a fetch is outstanding: nothing may be installed
      @(negedge clock);
      read = 1'b1; address = 8'h20;
      cycles = 0;
      while (!mem_read && cycles < 20) begin
         @(negedge clock);
         cycles++;
      end
      checkOutput("rst_fetch_started", {31'd0, mem_read}, 32'd1);
      @(negedge clock);
      #1 reset = 1'b1;
      #1;
      checkOutput("rst_mem_read", {31'd0, mem_read}, 32'd0);
      checkOutput("rst_mem_write", {31'd0, mem_write}, 32'd0);
      checkOutput("rst_busy", {31'd0, busywait}, 32'd0);
      checkOutput("rst_readdata", {24'd0, readdata}, 32'd0);
      model_reset();
      repeat (2) @(negedge clock);
      read = 1'b0;
      reset = 1'b0;
      applyStimulus(1'b1, 1'b0, 8'h20, 8'h00);

      // Random traffic
      for (int n = 0; n < 300; n++) begin
         r = int'($urandom_range(0, 9));
         a = 8'($urandom_range(0, 255));
         if (r == 0)      applyStimulus(1'b1, 1'b1, a, 8'($urandom));
         else if (r < 6)  applyStimulus(1'b1, 1'b0, a, 8'h00);
         else             applyStimulus(1'b0, 1'b1, a, 8'($urandom));
      end

      for (int i = 0; i < 64; i++) checkOutput("mem_word", mem_array[i], m_mem[i]);
      checkOutput("mem_exclusive", excl_viol, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
      $finish;
   end

endmodule
